// File: rtl/final_schematic_pkg.sv
// final_schematic_pkg
//   Shared definitions for the ticket/bar-code generator core.
//   - client_e : 2-bit client selection code
//   - dur_e    : 2-bit duration code (longest selected button wins)
//   - code_t   : packed layout of the 6-bit code {client, dur, chk}
//   - calc_chk : check field, (client + dur) mod 4
package final_schematic_pkg;

    localparam int FIELD_W = 2;
    localparam int CODE_W  = 3 * FIELD_W;

    typedef enum logic [FIELD_W-1:0] {
        CLI_NONE     = 2'b00,
        CLI_A        = 2'b01,
        CLI_B        = 2'b10,
        CLI_CONFLICT = 2'b11
    } client_e;

    typedef enum logic [FIELD_W-1:0] {
        DUR_NONE = 2'b00,
        DUR_30M  = 2'b01,
        DUR_1H   = 2'b10,
        DUR_2H   = 2'b11
    } dur_e;

    // Field order matches the printed code, MSB first.
    typedef struct packed {
        client_e             client;
        dur_e                dur;
        logic [FIELD_W-1:0]  chk;
    } code_t;

    // Two-bit add; the carry out is intentionally dropped.
    function automatic logic [FIELD_W-1:0] calc_chk(
        input logic [FIELD_W-1:0] client,
        input logic [FIELD_W-1:0] dur
    );
        logic [FIELD_W-1:0] sum;
        sum = client + dur;
        return sum;
    endfunction

endpackage

// File: rtl/final_schematic_code_encoder.sv
// code_encoder
//   Purely combinational mapping from the five front-panel levels to the
//   6-bit ticket code. Every input combination yields a defined code;
//   "none" and "conflict" are encoded rather than suppressed.
// Ports:
//   client_a, client_b       : client selection levels
//   btn_30m, btn_1h, btn_2h  : duration button levels
//   code                     : {client, dur, chk}
module code_encoder
    import final_schematic_pkg::*;
(
    input  logic              client_a,
    input  logic              client_b,
    input  logic              btn_30m,
    input  logic              btn_1h,
    input  logic              btn_2h,
    output logic [CODE_W-1:0] code
);

    client_e client;
    dur_e    dur;
    code_t   code_s;

    always_comb begin
        client = CLI_NONE;
        case ({client_b, client_a})
            2'b01:   client = CLI_A;
            2'b10:   client = CLI_B;
            2'b11:   client = CLI_CONFLICT;
            default: client = CLI_NONE;
        endcase
    end

    // Longest duration wins when several buttons are held.
    always_comb begin
        dur = DUR_NONE;
        if (btn_2h)
            dur = DUR_2H;
        else if (btn_1h)
            dur = DUR_1H;
        else if (btn_30m)
            dur = DUR_30M;
    end

    always_comb begin
        code_s.client = client;
        code_s.dur    = dur;
        code_s.chk    = calc_chk(client, dur);
    end

    assign code = code_s;

endmodule

// File: rtl/final_schematic.sv
// final_schematic
//   Ticket/bar-code generator core. Encodes the current button levels and
//   registers the result, so XLXN_25 follows the inputs with exactly one
//   cycle of latency. Port names are kept from the original schematic.
// Ports:
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset, clears the code
//   ClientA/B    : client selection levels
//   Button30Min, Button1Hour, Button2Hours : duration levels
//   XLXN_25      : registered 6-bit code {client, dur, chk}
module final_schematic
    import final_schematic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ClientA,
    input  logic              ClientB,
    input  logic              Button30Min,
    input  logic              Button1Hour,
    input  logic              Button2Hours,
    output logic [CODE_W-1:0] XLXN_25
);

    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] code_q;

    code_encoder u_enc (
        .client_a (ClientA),
        .client_b (ClientB),
        .btn_30m  (Button30Min),
        .btn_1h   (Button1Hour),
        .btn_2h   (Button2Hours),
        .code     (enc_code)
    );

    // Reset wins over sampling; no enable, the register reloads every edge.
    always_ff @(posedge clk) begin
        if (rst)
            code_q <= '0;
        else
            code_q <= enc_code;
    end

    assign XLXN_25 = code_q;

endmodule

// File: tb/tb_final_schematic.sv
module tb_final_schematic;

    logic       clk = 1'b0;
    logic       rst;
    logic       ClientA, ClientB, Button30Min, Button1Hour, Button2Hours;
    logic [5:0] XLXN_25;

    int checks = 0;
    int errors = 0;

    final_schematic dut (
        .clk          (clk),
        .rst          (rst),
        .ClientA      (ClientA),
        .ClientB      (ClientB),
        .Button30Min  (Button30Min),
        .Button1Hour  (Button1Hour),
        .Button2Hours (Button2Hours),
        .XLXN_25      (XLXN_25)
    );

    always #5 clk = ~clk;

    // Arithmetic model: client value is A + 2*B, duration is the longest
    // held button, check is the sum modulo 4.
    function automatic logic [5:0] model_code(input logic a, b, m30, h1, h2);
        int client, dur, chk;
        client = (a ? 1 : 0) + (b ? 2 : 0);
        if (h2)       dur = 3;
        else if (h1)  dur = 2;
        else if (m30) dur = 1;
        else          dur = 0;
        chk = (client + dur) % 4;
        return 6'(client * 16 + dur * 4 + chk);
    endfunction

    logic [5:0] exp_q;
    bit         exp_vld = 1'b0;

    always @(posedge clk) begin
        exp_q   <= rst ? 6'd0 : model_code(ClientA, ClientB, Button30Min, Button1Hour, Button2Hours);
        exp_vld <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_vld) begin
            checks++;
            if (XLXN_25 !== exp_q) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, XLXN_25, exp_q);
            end
        end
    end

    task automatic chk_lit(input string name, input logic [5:0] exp);
        checks++;
        if (XLXN_25 !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, XLXN_25, exp);
        end
    endtask

    task automatic pin_model(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, a, b, m30, h1, h2);
        rst = r; ClientA = a; ClientB = b;
        Button30Min = m30; Button1Hour = h1; Button2Hours = h2;
    endtask

    initial begin
        pin_model("model_conflict_1h", model_code(1, 1, 0, 1, 0), 6'b111001);
        pin_model("model_b_none",      model_code(0, 1, 0, 0, 0), 6'b100010);
        pin_model("model_all_high",    model_code(1, 1, 1, 1, 1), 6'b111110);

        // Reset held two edges with every input high.
        drive(1, 1, 1, 1, 1, 1);
        @(negedge clk); chk_lit("reset_edge1", 6'b000000);
        @(negedge clk); chk_lit("reset_edge2", 6'b000000);
        drive(0, 1, 1, 1, 1, 1);
        @(negedge clk); chk_lit("post_reset_all_high", 6'b111110);

        drive(0, 1, 1, 0, 1, 0);
        @(negedge clk); chk_lit("conflict_1h", 6'b111001);

        drive(0, 1, 0, 1, 0, 0);
        @(negedge clk); chk_lit("a_30m", 6'b010110);
        drive(0, 1, 0, 0, 0, 1);
        #1 chk_lit("a_2h_not_yet", 6'b010110);
        @(negedge clk); chk_lit("a_2h", 6'b011100);

        drive(0, 0, 1, 1, 1, 1);
        @(negedge clk); chk_lit("b_longest_wins", 6'b101101);

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); chk_lit("all_zero", 6'b000000);
        drive(0, 0, 1, 0, 0, 0);
        @(negedge clk); chk_lit("b_only", 6'b100010);

        // Reset in the middle of operation, then resume.
        drive(0, 1, 1, 0, 1, 0);
        @(negedge clk); chk_lit("pre_mid_reset", 6'b111001);
        drive(1, 1, 1, 0, 1, 0);
        @(negedge clk); chk_lit("mid_reset", 6'b000000);
        drive(0, 1, 1, 0, 1, 0);
        @(negedge clk); chk_lit("resume", 6'b111001);

        // Every input combination, with occasional resets; the model
        // checker covers these cycles.
        for (int i = 0; i < 64; i++) begin
            logic [4:0] v;
            v = 5'(i);
            drive((i % 9) == 8, v[0], v[1], v[2], v[3], v[4]);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
